mem_port_arb: RTL and testbench

- Sits directly upstream of the north-bridge memory controller and drives its byte-wide CPU-side read/write interface.
- Arbitrates between the instruction-fetch port and the data port of the MIPS64 core.
- Serialises each granted transaction into byte accesses, one byte per cycle.
- Assembles read bytes into little-endian words and returns them to the requester with a one-cycle done pulse.

---
 rtl/mem_port_arb.sv | 295 +++++++++++++++++++++++++++++
 tb/tb_mem_port_arb.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arb.sv
// mem_port_arb: arbitrates the MIPS64 instruction-fetch port and data port onto
// the byte-wide CPU-side interface of the north-bridge memory controller.
// Each granted transaction is split into byte accesses, one per cycle. Read
// bytes are assembled little-endian and returned with a one-cycle done pulse.
//
// Ports:
//   clk, rst                   clock; asynchronous active-low reset
//   i_req/i_addr               fetch request (4 bytes), held until i_done
//   i_rdata/i_done/i_err       fetch result, done pulse, misalignment flag
//   d_req/d_we/d_size/d_addr   data request (1/2/4/8 bytes), held until d_done
//   d_wdata                    store data, low n bytes used
//   d_rdata/d_done/d_err       load result (zero-extended), done pulse, error
//   mem_rdata                  read byte, valid the cycle after mem_re
//   mem_raddr/mem_re           read byte address and strobe
//   mem_waddr/mem_wdata/mem_we write byte address, data and strobe
//   busy                       high whenever a transaction is in progress
module mem_port_arb #(
    parameter int DATA_L   = 64,
    parameter int INST_L   = 32,
    parameter int ADDR_L   = 32,
    parameter int M_DATA_L = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_req,
    input  logic [ADDR_L-1:0]   i_addr,
    output logic [INST_L-1:0]   i_rdata,
    output logic                i_done,
    output logic                i_err,
    input  logic                d_req,
    input  logic                d_we,
    input  logic [1:0]          d_size,
    input  logic [ADDR_L-1:0]   d_addr,
    input  logic [DATA_L-1:0]   d_wdata,
    output logic [DATA_L-1:0]   d_rdata,
    output logic                d_done,
    output logic                d_err,
    input  logic [M_DATA_L-1:0] mem_rdata,
    output logic [M_DATA_L-1:0] mem_wdata,
    output logic [ADDR_L-1:0]   mem_raddr,
    output logic [ADDR_L-1:0]   mem_waddr,
    output logic                mem_re,
    output logic                mem_we,
    output logic                busy
);

    localparam int NBYTES = DATA_L / 8;
    localparam int CNT_W  = $clog2(NBYTES);
    localparam int N_W    = CNT_W + 1;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD      = 3'd1,
        RD_TAIL = 3'd2,
        WR      = 3'd3,
        DONE    = 3'd4
    } state_t;

    // Replace byte idx of a buffer word.
    function automatic logic [DATA_L-1:0] set_byte(input logic [DATA_L-1:0] v,
                                                   input logic [CNT_W-1:0] idx,
                                                   input logic [M_DATA_L-1:0] b);
        logic [DATA_L-1:0] r;
        r = v;
        r[{idx, 3'b000} +: M_DATA_L] = b;
        return r;
    endfunction

    // Extract byte idx of a data word.
    function automatic logic [M_DATA_L-1:0] get_byte(input logic [DATA_L-1:0] v,
                                                     input logic [CNT_W-1:0] idx);
        return v[{idx, 3'b000} +: M_DATA_L];
    endfunction

    state_t              state_r, state_nx_s;
    logic                owner_r, owner_nx_s;   // 1 = data port, 0 = fetch port
    logic [ADDR_L-1:0]   base_r, base_nx_s;
    logic [N_W-1:0]      n_r, n_nx_s;
    logic [CNT_W-1:0]    cnt_r, cnt_nx_s;
    logic                we_r, we_nx_s;
    logic [DATA_L-1:0]   wdata_r, wdata_nx_s;
    logic                err_r, err_nx_s;
    logic [DATA_L-1:0]   buf_r, buf_nx_s;
    logic                last_s;

    logic                g_owner_s, g_we_s, g_err_s;
    logic [ADDR_L-1:0]   g_addr_s;
    logic [N_W-1:0]      g_n_s;
    logic [DATA_L-1:0]   g_wdata_s;

    logic [INST_L-1:0]   i_rdata_nx_s, i_rdata_r;
    logic                i_done_nx_s, i_done_r, i_err_nx_s, i_err_r;
    logic [DATA_L-1:0]   d_rdata_nx_s, d_rdata_r;
    logic                d_done_nx_s, d_done_r, d_err_nx_s, d_err_r;
    logic [M_DATA_L-1:0] mem_wdata_nx_s, mem_wdata_r;
    logic [ADDR_L-1:0]   mem_raddr_nx_s, mem_raddr_r, mem_waddr_nx_s, mem_waddr_r;
    logic                mem_re_nx_s, mem_re_r, mem_we_nx_s, mem_we_r;
    logic                busy_nx_s, busy_r;

    // Candidate grant: data port has fixed priority over the fetch port.
    always_comb begin
        if (d_req) begin
            g_owner_s = 1'b1;
            g_addr_s  = d_addr;
            g_n_s     = N_W'(1'b1) << d_size;
            g_we_s    = d_we;
            g_wdata_s = d_wdata;
        end else begin
            g_owner_s = 1'b0;
            g_addr_s  = i_addr;
            g_n_s     = N_W'(INST_L / 8);
            g_we_s    = 1'b0;
            g_wdata_s = {DATA_L{1'b0}};
        end
        g_err_s = ((g_addr_s & (ADDR_L'(g_n_s) - ADDR_L'(1'b1))) != {ADDR_L{1'b0}});
    end

    assign last_s = ({1'b0, cnt_r} == (n_r - N_W'(1'b1)));

    // Next-state and transaction-context logic.
    always_comb begin
        state_nx_s = state_r;
        owner_nx_s = owner_r;
        base_nx_s  = base_r;
        n_nx_s     = n_r;
        cnt_nx_s   = cnt_r;
        we_nx_s    = we_r;
        wdata_nx_s = wdata_r;
        err_nx_s   = err_r;
        buf_nx_s   = buf_r;
        case (state_r)
            IDLE: begin
                if (d_req || i_req) begin
                    owner_nx_s = g_owner_s;
                    base_nx_s  = g_addr_s;
                    n_nx_s     = g_n_s;
                    we_nx_s    = g_we_s;
                    wdata_nx_s = g_wdata_s;
                    err_nx_s   = g_err_s;
                    cnt_nx_s   = {CNT_W{1'b0}};
                    buf_nx_s   = {DATA_L{1'b0}};
                    if (g_err_s) begin
                        state_nx_s = DONE;
                    end else if (g_we_s) begin
                        state_nx_s = WR;
                    end else begin
                        state_nx_s = RD;
                    end
                end else begin
                    state_nx_s = IDLE;
                end
            end
            RD: begin
                cnt_nx_s = cnt_r + CNT_W'(1'b1);
                // mem_rdata now carries the byte addressed in the previous cycle.
                if (cnt_r != {CNT_W{1'b0}}) begin
                    buf_nx_s = set_byte(buf_r, cnt_r - CNT_W'(1'b1), mem_rdata);
                end else begin
                    buf_nx_s = buf_r;
                end
                if (last_s) begin
                    state_nx_s = RD_TAIL;
                end else begin
                    state_nx_s = RD;
                end
            end
            RD_TAIL: begin
                buf_nx_s   = set_byte(buf_r, CNT_W'(n_r - N_W'(1'b1)), mem_rdata);
                state_nx_s = DONE;
            end
            WR: begin
                cnt_nx_s = cnt_r + CNT_W'(1'b1);
                if (last_s) begin
                    state_nx_s = DONE;
                end else begin
                    state_nx_s = WR;
                end
            end
            DONE: begin
                state_nx_s = IDLE;
            end
            default: begin
                state_nx_s = IDLE;
            end
        endcase
    end

    // Output values for the coming cycle, decoded from the next-state context
    // so every port can be driven straight from a flop.
    always_comb begin
        i_rdata_nx_s   = {INST_L{1'b0}};
        i_done_nx_s    = 1'b0;
        i_err_nx_s     = 1'b0;
        d_rdata_nx_s   = {DATA_L{1'b0}};
        d_done_nx_s    = 1'b0;
        d_err_nx_s     = 1'b0;
        mem_wdata_nx_s = {M_DATA_L{1'b0}};
        mem_raddr_nx_s = {ADDR_L{1'b0}};
        mem_waddr_nx_s = {ADDR_L{1'b0}};
        mem_re_nx_s    = 1'b0;
        mem_we_nx_s    = 1'b0;
        busy_nx_s      = (state_nx_s != IDLE);
        if (state_nx_s == RD) begin
            mem_re_nx_s    = 1'b1;
            mem_raddr_nx_s = base_nx_s + ADDR_L'(cnt_nx_s);
        end else if (state_nx_s == WR) begin
            mem_we_nx_s    = 1'b1;
            mem_waddr_nx_s = base_nx_s + ADDR_L'(cnt_nx_s);
            mem_wdata_nx_s = get_byte(wdata_nx_s, cnt_nx_s);
        end else if (state_nx_s == DONE) begin
            // Buffer is cleared on grant, so bytes at index n and above read 0.
            if (owner_nx_s) begin
                d_done_nx_s  = 1'b1;
                d_err_nx_s   = err_nx_s;
                d_rdata_nx_s = buf_nx_s;
            end else begin
                i_done_nx_s  = 1'b1;
                i_err_nx_s   = err_nx_s;
                i_rdata_nx_s = buf_nx_s[INST_L-1:0];
            end
        end else begin
            busy_nx_s = busy_nx_s;
        end
    end

    // Transaction state registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= IDLE;
            owner_r <= 1'b0;
            base_r  <= {ADDR_L{1'b0}};
            n_r     <= {N_W{1'b0}};
            cnt_r   <= {CNT_W{1'b0}};
            we_r    <= 1'b0;
            wdata_r <= {DATA_L{1'b0}};
            err_r   <= 1'b0;
            buf_r   <= {DATA_L{1'b0}};
        end else begin
            state_r <= state_nx_s;
            owner_r <= owner_nx_s;
            base_r  <= base_nx_s;
            n_r     <= n_nx_s;
            cnt_r   <= cnt_nx_s;
            we_r    <= we_nx_s;
            wdata_r <= wdata_nx_s;
            err_r   <= err_nx_s;
            buf_r   <= buf_nx_s;
        end
    end

    // Output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            i_rdata_r   <= {INST_L{1'b0}};
            i_done_r    <= 1'b0;
            i_err_r     <= 1'b0;
            d_rdata_r   <= {DATA_L{1'b0}};
            d_done_r    <= 1'b0;
            d_err_r     <= 1'b0;
            mem_wdata_r <= {M_DATA_L{1'b0}};
            mem_raddr_r <= {ADDR_L{1'b0}};
            mem_waddr_r <= {ADDR_L{1'b0}};
            mem_re_r    <= 1'b0;
            mem_we_r    <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            i_rdata_r   <= i_rdata_nx_s;
            i_done_r    <= i_done_nx_s;
            i_err_r     <= i_err_nx_s;
            d_rdata_r   <= d_rdata_nx_s;
            d_done_r    <= d_done_nx_s;
            d_err_r     <= d_err_nx_s;
            mem_wdata_r <= mem_wdata_nx_s;
            mem_raddr_r <= mem_raddr_nx_s;
            mem_waddr_r <= mem_waddr_nx_s;
            mem_re_r    <= mem_re_nx_s;
            mem_we_r    <= mem_we_nx_s;
            busy_r      <= busy_nx_s;
        end
    end

    assign i_rdata   = i_rdata_r;
    assign i_done    = i_done_r;
    assign i_err     = i_err_r;
    assign d_rdata   = d_rdata_r;
    assign d_done    = d_done_r;
    assign d_err     = d_err_r;
    assign mem_wdata = mem_wdata_r;
    assign mem_raddr = mem_raddr_r;
    assign mem_waddr = mem_waddr_r;
    assign mem_re    = mem_re_r;
    assign mem_we    = mem_we_r;
    assign busy      = busy_r;

endmodule

// File: tb/tb_mem_port_arb.sv
// Directed bench for mem_port_arb with a byte-wide memory model.
module tb_mem_port_arb;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_req;
    logic [31:0] i_addr;
    logic [31:0] i_rdata;
    logic        i_done, i_err;
    logic        d_req, d_we;
    logic [1:0]  d_size;
    logic [31:0] d_addr;
    logic [63:0] d_wdata, d_rdata;
    logic        d_done, d_err;
    logic [7:0]  mem_rdata = 8'h00;
    logic [7:0]  mem_wdata;
    logic [31:0] mem_raddr, mem_waddr;
    logic        mem_re, mem_we, busy;

    int n_cmp = 0;
    int n_bad = 0;

    mem_port_arb dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_done(i_done), .i_err(i_err),
        .d_req(d_req), .d_we(d_we), .d_size(d_size), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_done(d_done), .d_err(d_err),
        .mem_rdata(mem_rdata), .mem_wdata(mem_wdata), .mem_raddr(mem_raddr),
        .mem_waddr(mem_waddr), .mem_re(mem_re), .mem_we(mem_we), .busy(busy)
    );

    always #5 clk = ~clk;

    // Memory model: 4 KiB image indexed by the low 12 address bits.
    logic [7:0] mem [0:4095];
    logic       fill_done = 1'b0;
    always @(posedge clk) begin
        if (!fill_done) begin
            for (int a = 0; a < 4096; a++) mem[a] <= 8'(a);
            mem[12'h100] <= 8'h11;
            mem[12'h101] <= 8'h22;
            mem[12'h102] <= 8'h33;
            mem[12'h103] <= 8'h44;
            mem[12'h3FF] <= 8'hAB;
            fill_done    <= 1'b1;
        end else begin
            if (mem_re) mem_rdata <= mem[mem_raddr[11:0]];
            if (mem_we) mem[mem_waddr[11:0]] <= mem_wdata;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        is_d;
        logic        we;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [63:0] wdata;
        logic [63:0] rdata;
        logic        err;
        int          lat;
        int          nre;
        int          nwe;
    } vec_t;

    vec_t tbl [14];

    // Issue one request at the current negedge, follow it to done, check it.
    task automatic run_txn(input vec_t v, input string tag);
        int          k, nre, nwe;
        logic        got, seen_other, er;
        logic [63:0] rd, wd;
        logic [31:0] exp_a;
        k = 0; nre = 0; nwe = 0; got = 1'b0; seen_other = 1'b0; er = 1'b0;
        rd = 64'h0; wd = v.wdata;
        if (v.is_d) begin
            d_req = 1'b1; d_we = v.we; d_size = v.size; d_addr = v.addr; d_wdata = v.wdata;
        end else begin
            i_req = 1'b1; i_addr = v.addr;
        end
        while (!got && k < 40) begin
            @(negedge clk);
            k++;
            chk({tag, "_re_we_excl"}, {63'h0, mem_re & mem_we}, 64'h0);
            if (mem_re) begin
                exp_a = v.addr + 32'(nre);
                chk({tag, "_raddr"}, {32'h0, mem_raddr}, {32'h0, exp_a});
                nre++;
            end
            if (mem_we && nwe < 8) begin
                exp_a = v.addr + 32'(nwe);
                chk({tag, "_waddr"}, {32'h0, mem_waddr}, {32'h0, exp_a});
                chk({tag, "_wdata"}, {56'h0, mem_wdata}, {56'h0, wd[8*nwe +: 8]});
                nwe++;
            end
            if (v.is_d ? i_done : d_done) seen_other = 1'b1;
            if (v.is_d ? d_done : i_done) begin
                got = 1'b1;
                rd  = v.is_d ? d_rdata : {32'h0, i_rdata};
                er  = v.is_d ? d_err : i_err;
            end
        end
        d_req = 1'b0; i_req = 1'b0;
        chk({tag, "_latency"}, got ? 64'(k) : 64'hFFFF_FFFF_FFFF_FFFF, 64'(v.lat));
        chk({tag, "_rdata"}, rd, v.rdata);
        chk({tag, "_err"}, {63'h0, er}, {63'h0, v.err});
        chk({tag, "_n_reads"}, 64'(nre), 64'(v.nre));
        chk({tag, "_n_writes"}, 64'(nwe), 64'(v.nwe));
        chk({tag, "_other_done"}, {63'h0, seen_other}, 64'h0);
        @(negedge clk);
        chk({tag, "_idle_busy"}, {63'h0, busy}, 64'h0);
    endtask

    initial begin
        int          dk, ik, c;
        logic [63:0] drd;
        logic [31:0] ird;
        logic        busy4, seen;

        rst = 1'b0; i_req = 1'b0; i_addr = 32'h0; d_req = 1'b0; d_we = 1'b0;
        d_size = 2'd0; d_addr = 32'h0; d_wdata = 64'h0;

        //        is_d  we    size  addr          wdata                  rdata                  err  lat nre nwe
        tbl[0]  = '{1'b0, 1'b0, 2'd0, 32'h0000_0100, 64'h0,                 64'h44332211,          1'b0, 6,  4, 0};
        tbl[1]  = '{1'b1, 1'b1, 2'd3, 32'h0000_0208, 64'h0807060504030201, 64'h0,                 1'b0, 9,  0, 8};
        tbl[2]  = '{1'b1, 1'b0, 2'd3, 32'h0000_0208, 64'h0,                 64'h0807060504030201, 1'b0, 10, 8, 0};
        tbl[3]  = '{1'b1, 1'b0, 2'd1, 32'h0000_0101, 64'h0,                 64'h0,                 1'b1, 1,  0, 0};
        tbl[4]  = '{1'b1, 1'b0, 2'd0, 32'h0000_03FF, 64'h0,                 64'hAB,                1'b0, 3,  1, 0};
        tbl[5]  = '{1'b1, 1'b1, 2'd1, 32'h0000_020A, 64'hFFFFFFFFFFFFBEEF, 64'h0,                 1'b0, 3,  0, 2};
        tbl[6]  = '{1'b1, 1'b0, 2'd2, 32'h0000_0208, 64'h0,                 64'hBEEF0201,          1'b0, 6,  4, 0};
        tbl[7]  = '{1'b0, 1'b0, 2'd0, 32'h0000_0102, 64'h0,                 64'h0,                 1'b1, 1,  0, 0};
        tbl[8]  = '{1'b1, 1'b1, 2'd2, 32'h0000_020A, 64'h1122334455667788, 64'h0,                 1'b1, 1,  0, 0};
        tbl[9]  = '{1'b1, 1'b0, 2'd1, 32'h0000_020C, 64'h0,                 64'h0605,              1'b0, 4,  2, 0};
        tbl[10] = '{1'b0, 1'b0, 2'd0, 32'h0000_0208, 64'h0,                 64'hBEEF0201,          1'b0, 6,  4, 0};
        tbl[11] = '{1'b1, 1'b0, 2'd2, 32'hFFFF_FFFC, 64'h0,                 64'hFFFEFDFC,          1'b0, 6,  4, 0};
        tbl[12] = '{1'b1, 1'b1, 2'd0, 32'h0000_03FF, 64'h000000000000005A, 64'h0,                 1'b0, 2,  0, 1};
        tbl[13] = '{1'b1, 1'b0, 2'd0, 32'h0000_03FF, 64'h0,                 64'h5A,                1'b0, 3,  1, 0};

        // Reset state.
        #2;
        chk("rst_busy", {63'h0, busy}, 64'h0);
        chk("rst_strobes", {62'h0, mem_re, mem_we}, 64'h0);
        chk("rst_done", {62'h0, i_done, d_done}, 64'h0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 14; i++) run_txn(tbl[i], $sformatf("v%0d", i));

        // Simultaneous requests: data first, then one idle cycle, then fetch.
        d_req = 1'b1; d_we = 1'b0; d_size = 2'd0; d_addr = 32'h3FF;
        i_req = 1'b1; i_addr = 32'h100;
        dk = -1; ik = -1; drd = 64'h0; ird = 32'h0; busy4 = 1'b1;
        c = 0;
        while (ik < 0 && c < 30) begin
            @(negedge clk);
            c++;
            if (d_done && dk < 0) begin dk = c; drd = d_rdata; d_req = 1'b0; end
            if (c == 4) busy4 = busy;
            if (i_done && ik < 0) begin ik = c; ird = i_rdata; i_req = 1'b0; end
        end
        d_req = 1'b0; i_req = 1'b0;
        chk("sim_d_done_cycle", 64'(dk), 64'd3);
        chk("sim_d_rdata", drd, 64'h5A);
        chk("sim_idle_gap", {63'h0, busy4}, 64'h0);
        chk("sim_i_done_cycle", 64'(ik), 64'd10);
        chk("sim_i_rdata", {32'h0, ird}, 64'h44332211);
        @(negedge clk);

        // Reset during a word store, after three bytes have committed.
        d_req = 1'b1; d_we = 1'b1; d_size = 2'd2; d_addr = 32'h208; d_wdata = 64'hDDCCBBAA;
        repeat (4) @(negedge clk);
        chk("rstmid_we_before", {63'h0, mem_we}, 64'h1);
        rst = 1'b0;
        #1;
        chk("rstmid_we", {63'h0, mem_we}, 64'h0);
        chk("rstmid_busy", {63'h0, busy}, 64'h0);
        chk("rstmid_waddr", {32'h0, mem_waddr}, 64'h0);
        d_req = 1'b0;
        seen = 1'b0;
        repeat (2) begin
            @(negedge clk);
            if (d_done) seen = 1'b1;
        end
        rst = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (d_done || busy) seen = 1'b1;
        end
        chk("rstmid_no_done", {63'h0, seen}, 64'h0);
        run_txn('{1'b1, 1'b0, 2'd2, 32'h208, 64'h0, 64'hBECCBBAA, 1'b0, 6, 4, 0}, "after_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
